// File: rtl/axilite_led_regs.sv
// AXI4-Lite register block behind the PCIe BAR. It holds the ID, scratch, LED control,
// blink divider and cycle counter registers, and drives the active-low board LEDs.
module axilite_led_regs #(
   parameter logic [31:0] ID_VALUE      = 32'hAC0E_0215,
   parameter logic [31:0] BLINK_DIV_RST = 32'd62_500_000,
   parameter int unsigned NUM_LEDS      = 4
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [31:0]         s_awaddr,
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [31:0]         s_wdata,
   input  logic [3:0]          s_wstrb,
   input  logic                s_wvalid,
   output logic                s_wready,
   output logic [1:0]          s_bresp,
   output logic                s_bvalid,
   input  logic                s_bready,
   input  logic [31:0]         s_araddr,
   input  logic                s_arvalid,
   output logic                s_arready,
   output logic [31:0]         s_rdata,
   output logic [1:0]          s_rresp,
   output logic                s_rvalid,
   input  logic                s_rready,
   output logic [NUM_LEDS-1:0] LEDn
);

   localparam int unsigned DW  = 32;
   localparam int unsigned IW  = 10;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [DW-1:0] RD_ERR_DATA = 32'hDEAD_BEEF;
   localparam logic [DW-1:0] ON_MASK  = DW'((33'd1 << NUM_LEDS) - 33'd1);
   localparam logic [DW-1:0] LED_MASK = ON_MASK | (ON_MASK << 8);
   localparam logic [IW-1:0] IDX_ID      = IW'(0);
   localparam logic [IW-1:0] IDX_SCRATCH = IW'(1);
   localparam logic [IW-1:0] IDX_LED     = IW'(2);
   localparam logic [IW-1:0] IDX_DIV     = IW'(3);
   localparam logic [IW-1:0] IDX_CYC     = IW'(4);

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state, w_nxt;
   r_state_t r_state, r_nxt;

   logic [IW-1:0] awaddr_q;
   logic [DW-1:0] wdata_q;
   logic [3:0]    wstrb_q;
   logic [DW-1:0] scratch, led_ctrl, blink_div, blink_timer, cycle_cnt;
   logic          blink_phase;

   logic          aw_hs, w_hs, ar_hs;
   logic          wr_commit, wr_ok, div_wr, blink_tc;
   logic [IW-1:0] wr_idx;
   logic [DW-1:0] wr_data, wr_merged;
   logic [3:0]    wr_strb;
   logic          awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
   logic [DW-1:0] rd_data;
   logic [1:0]    rd_resp;
   logic [NUM_LEDS-1:0] led_on;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^{s_awaddr[31:12], s_awaddr[1:0], s_araddr[31:12], s_araddr[1:0]};

   assign aw_hs = s_awvalid & s_awready;
   assign w_hs  = s_wvalid & s_wready;
   assign ar_hs = s_arvalid & s_arready;

   // Write FSM: state register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) w_state <= W_IDLE;
      else        w_state <= w_nxt;
   end

   // Write FSM: next state
   always_comb begin
      w_nxt = w_state;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) w_nxt = W_RESP;
            else if (aw_hs)    w_nxt = W_HAVE_AW;
            else if (w_hs)     w_nxt = W_HAVE_W;
         end
         W_HAVE_AW: if (w_hs)     w_nxt = W_RESP;
         W_HAVE_W:  if (aw_hs)    w_nxt = W_RESP;
         W_RESP:    if (s_bready) w_nxt = W_IDLE;
         default:   w_nxt = W_IDLE;
      endcase
   end

   // Write FSM: outputs and commit decode; held channel comes from the capture regs
   always_comb begin
      wr_commit = (w_state != W_RESP) && (w_nxt == W_RESP);
      wr_idx    = (w_state == W_HAVE_AW) ? awaddr_q : s_awaddr[11:2];
      wr_data   = (w_state == W_HAVE_W) ? wdata_q : s_wdata;
      wr_strb   = (w_state == W_HAVE_W) ? wstrb_q : s_wstrb;
      wr_ok     = (wr_idx == IDX_SCRATCH) || (wr_idx == IDX_LED) || (wr_idx == IDX_DIV);
      div_wr    = wr_commit && (wr_idx == IDX_DIV) && (wr_strb != 4'b0000);
      awready_d = (w_nxt == W_IDLE) || (w_nxt == W_HAVE_W);
      wready_d  = (w_nxt == W_IDLE) || (w_nxt == W_HAVE_AW);
      bvalid_d  = (w_nxt == W_RESP);
      wr_merged = '0;
      for (int b = 0; b < 4; b++) begin
         wr_merged[8*b +: 8] = wr_data[8*b +: 8];
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bresp   <= RESP_OKAY;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         s_awready <= awready_d;
         s_wready  <= wready_d;
         s_bvalid  <= bvalid_d;
         if (wr_commit) s_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (aw_hs) awaddr_q <= s_awaddr[11:2];
         if (w_hs) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
         end
      end
   end

   // Register file; unwritten strobe lanes keep their old byte
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         scratch   <= '0;
         led_ctrl  <= '0;
         blink_div <= BLINK_DIV_RST;
      end else if (wr_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
               case (wr_idx)
                  IDX_SCRATCH: scratch[8*b +: 8]   <= wr_merged[8*b +: 8];
                  IDX_LED:     led_ctrl[8*b +: 8]  <= wr_merged[8*b +: 8] & LED_MASK[8*b +: 8];
                  IDX_DIV:     blink_div[8*b +: 8] <= wr_merged[8*b +: 8];
                  default: ;
               endcase
            end
         end
      end
   end

   // Blink timer; divider 0 or 1 degenerates to a toggle every cycle
   assign blink_tc = (blink_div <= 32'd1) || (blink_timer >= blink_div - 32'd1);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         blink_timer <= '0;
         blink_phase <= 1'b1;
         cycle_cnt   <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (div_wr) begin
            blink_timer <= '0;
            blink_phase <= 1'b1;
         end else if (blink_tc) begin
            blink_timer <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_timer <= blink_timer + 32'd1;
         end
      end
   end

   assign led_on = led_ctrl[NUM_LEDS-1:0] & (~led_ctrl[8 +: NUM_LEDS] | {NUM_LEDS{blink_phase}});

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) LEDn <= '1;
      else        LEDn <= ~led_on;
   end

   // Read FSM: state register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) r_state <= R_IDLE;
      else        r_state <= r_nxt;
   end

   // Read FSM: next state
   always_comb begin
      r_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs)    r_nxt = R_DATA;
         R_DATA:  if (s_rready) r_nxt = R_IDLE;
         default: r_nxt = R_IDLE;
      endcase
   end

   // Read FSM: outputs and read mux (pre-update register values)
   always_comb begin
      arready_d = (r_nxt == R_IDLE);
      rvalid_d  = (r_nxt == R_DATA);
      rd_data   = RD_ERR_DATA;
      rd_resp   = RESP_SLVERR;
      case (s_araddr[11:2])
         IDX_ID:      begin rd_data = ID_VALUE;  rd_resp = RESP_OKAY; end
         IDX_SCRATCH: begin rd_data = scratch;   rd_resp = RESP_OKAY; end
         IDX_LED:     begin rd_data = led_ctrl;  rd_resp = RESP_OKAY; end
         IDX_DIV:     begin rd_data = blink_div; rd_resp = RESP_OKAY; end
         IDX_CYC:     begin rd_data = cycle_cnt; rd_resp = RESP_OKAY; end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rdata   <= '0;
         s_rresp   <= RESP_OKAY;
      end else begin
         s_arready <= arready_d;
         s_rvalid  <= rvalid_d;
         if (ar_hs) begin
            s_rdata <= rd_data;
            s_rresp <= rd_resp;
         end
      end
   end

endmodule

// File: tb/tb_axilite_led_regs.sv
// Randomized scoreboard bench for axilite_led_regs: a register-map model predicts every
// response and the LED pattern; directed phases cover timing and reset-abort behaviour.
module tb_axilite_led_regs;
   localparam int unsigned NL = 4;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic [31:0]   s_awaddr = '0, s_wdata = '0, s_araddr = '0;
   logic [3:0]    s_wstrb = '0;
   logic          s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
   logic          s_bready = 1'b0, s_rready = 1'b0;
   logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]    s_bresp, s_rresp;
   logic [31:0]   s_rdata;
   logic [NL-1:0] LEDn;

   axilite_led_regs #(.NUM_LEDS(NL)) dut (
      .aclk(aclk), .areset(areset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .LEDn(LEDn)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {logic [31:0] data; logic [1:0] resp;} rd_exp_t;
   rd_exp_t    exp_r[$];
   logic [1:0] exp_b[$];

   logic [31:0] m_scratch = '0, m_ledctrl = '0, m_div = 32'd62_500_000, m_cyc = '0;
   longint      m_cnt = 0;
   bit          m_phase = 1'b1;
   bit          m_have_aw = 0, m_have_w = 0;
   logic [31:0] m_awaddr = '0, m_wdata = '0;
   logic [3:0]  m_wstrb = '0;
   logic [NL-1:0] exp_ledn = '1;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] led_mask();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < NL; i++) begin m[i] = 1'b1; m[8+i] = 1'b1; end
      return m;
   endfunction

   function automatic rd_exp_t model_read(input logic [31:0] a);
      rd_exp_t e;
      e.resp = 2'b00;
      case (int'(a[11:2]))
         0: e.data = 32'hAC0E_0215;
         1: e.data = m_scratch;
         2: e.data = m_ledctrl;
         3: e.data = m_div;
         4: e.data = m_cyc;
         default: begin e.data = 32'hDEAD_BEEF; e.resp = 2'b10; end
      endcase
      return e;
   endfunction

   always @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_scratch = '0; m_ledctrl = '0; m_div = 32'd62_500_000; m_cyc = '0;
         m_cnt = 0; m_phase = 1'b1; m_have_aw = 0; m_have_w = 0;
         exp_r.delete(); exp_b.delete(); exp_ledn = '1;
      end else begin
         bit div_written;
         div_written = 0;
         for (int i = 0; i < NL; i++)
            exp_ledn[i] = !(m_ledctrl[i] && (!m_ledctrl[8+i] || m_phase));
         if (s_arvalid && s_arready) exp_r.push_back(model_read(s_araddr));
         if (s_awvalid && s_awready) begin m_have_aw = 1; m_awaddr = s_awaddr; end
         if (s_wvalid && s_wready) begin m_have_w = 1; m_wdata = s_wdata; m_wstrb = s_wstrb; end
         if (m_have_aw && m_have_w) begin
            case (int'(m_awaddr[11:2]))
               1: begin m_scratch = merge(m_scratch, m_wdata, m_wstrb); exp_b.push_back(2'b00); end
               2: begin m_ledctrl = merge(m_ledctrl, m_wdata, m_wstrb) & led_mask(); exp_b.push_back(2'b00); end
               3: begin
                  m_div = merge(m_div, m_wdata, m_wstrb);
                  div_written = (m_wstrb != 4'b0000);
                  exp_b.push_back(2'b00);
               end
               default: exp_b.push_back(2'b10);
            endcase
            m_have_aw = 0; m_have_w = 0;
         end
         // phase flips once every max(BLINK_DIV,1) cycles since the last restart
         if (div_written) begin
            m_cnt = 0; m_phase = 1'b1;
         end else begin
            m_cnt++;
            if (m_cnt >= ((m_div < 2) ? 64'd1 : longint'(m_div))) begin
               m_cnt = 0; m_phase = !m_phase;
            end
         end
         m_cyc = m_cyc + 32'd1;
      end
   end

   // ---------------- monitors ----------------
   always @(posedge aclk) begin
      if (!areset) begin
         if (s_bvalid) begin
            if (exp_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL bresp_unexpected: bvalid with no write outstanding (t=%0t)", $time);
            end else if (s_bready) begin
               check("bresp", 32'(s_bresp), 32'(exp_b.pop_front()));
            end
         end
         if (s_rvalid) begin
            if (exp_r.size() == 0) begin
               checks++; errors++;
               $display("FAIL rvalid_unexpected: rvalid with no read outstanding (t=%0t)", $time);
            end else if (s_rready) begin
               rd_exp_t e;
               e = exp_r.pop_front();
               check("rdata", s_rdata, e.data);
               check("rresp", 32'(s_rresp), 32'(e.resp));
            end
         end
      end
   end

   always @(negedge aclk) if (!areset) check("ledn", 32'(LEDn), 32'(exp_ledn));

   // ready generators: 0 random, 1 held high, 2 held low
   int bready_mode = 1, rready_mode = 1;
   always @(negedge aclk) begin
      s_bready = (bready_mode == 0) ? ($urandom_range(0, 3) != 0) : (bready_mode == 1);
      s_rready = (rready_mode == 0) ? ($urandom_range(0, 3) != 0) : (rready_mode == 1);
   end

   // ---------------- drivers ----------------
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
      bit aw_done = 0, w_done = 0;
      int t = 0;
      while (!(aw_done && w_done)) begin
         @(negedge aclk);
         s_awaddr = addr; s_wdata = data; s_wstrb = strb;
         s_awvalid = !aw_done && (t >= aw_dly);
         s_wvalid  = !w_done && (t >= w_dly);
         @(posedge aclk);
         if (s_awvalid && s_awready) aw_done = 1;
         if (s_wvalid && s_wready) w_done = 1;
         t++;
         if (t > 300) begin
            check("write_timeout", 32'(t), 32'd0);
            break;
         end
      end
      @(negedge aclk);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int dly);
      int t = 0;
      repeat (dly) @(negedge aclk);
      forever begin
         @(negedge aclk);
         s_araddr = addr; s_arvalid = 1'b1;
         @(posedge aclk);
         if (s_arready) break;
         t++;
         if (t > 300) begin check("read_timeout", 32'(t), 32'd0); break; end
      end
      @(negedge aclk);
      s_arvalid = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a, hi;
      hi = $urandom();
      case ($urandom_range(0, 7))
         0, 1, 2, 3, 4: a = 32'($urandom_range(0, 4)) << 2;
         5:             a = 32'h20;
         default:       a = 32'($urandom_range(0, 1023)) << 2;
      endcase
      return {hi[31:12], a[11:2], 2'($urandom_range(0, 3))};
   endfunction

   // ---------------- sequence ----------------
   initial begin
      int nt, last, prev_bit;
      bit ok;
      logic [1:0] held_bresp;

      repeat (3) @(negedge aclk);
      check("rst_awready", 32'(s_awready), 0);
      check("rst_wready",  32'(s_wready), 0);
      check("rst_arready", 32'(s_arready), 0);
      check("rst_bvalid",  32'(s_bvalid), 0);
      check("rst_rvalid",  32'(s_rvalid), 0);
      check("rst_rdata",   s_rdata, 0);
      check("rst_bresp_rresp", 32'({s_bresp, s_rresp}), 0);
      check("rst_ledn",    32'(LEDn), 32'hF);
      #1 areset = 1'b0;
      @(negedge aclk);
      check("post_rst_readies", 32'({s_awready, s_wready, s_arready}), 32'h7);

      // reset values
      do_read(32'h0, 0); do_read(32'h4, 0); do_read(32'hC, 0);
      // byte strobes
      do_write(32'h4, 32'h1234_5678, 4'b0101, 0, 0);
      do_read(32'h4, 0);

      // AW leads W by five cycles
      @(negedge aclk);
      s_awaddr = 32'h8; s_awvalid = 1'b1; s_wvalid = 1'b0;
      @(posedge aclk);
      check("t3_aw_accept", 32'(s_awready), 1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge aclk);
         s_awvalid = 1'b0;
         check("t3_awready_low", 32'(s_awready), 0);
         check("t3_bvalid_low", 32'(s_bvalid), 0);
         if (k == 5) begin s_wdata = 32'h3; s_wstrb = 4'hF; s_wvalid = 1'b1; end
         @(posedge aclk);
      end
      @(negedge aclk);
      s_wvalid = 1'b0;
      check("t3_bvalid_c6", 32'(s_bvalid), 1);
      check("t3_readies_resp", 32'({s_awready, s_wready}), 0);
      check("t3_ledn_c6", 32'(LEDn), 32'hF);
      @(negedge aclk);
      check("t3_ledn_c7", 32'(LEDn), 32'hC);

      // blink on LED0, period 4
      do_write(32'hC, 32'd4, 4'hF, 0, 1);
      do_write(32'h8, 32'h101, 4'hF, 1, 0);
      last = -1; nt = 0; ok = 1; prev_bit = int'(LEDn[0]);
      for (int c = 0; c < 40; c++) begin
         @(negedge aclk);
         if (LEDn[3:1] != 3'b111) ok = 0;
         if (int'(LEDn[0]) != prev_bit) begin
            if (last >= 0) check("t4_blink_period", 32'(c - last), 32'd4);
            last = c; nt++; prev_bit = int'(LEDn[0]);
         end
      end
      check("t4_upper_leds_off", 32'(ok), 1);
      check("t4_toggles_seen", 32'(nt >= 8), 1);

      // error responses, counter keeps running
      do_read(32'h20, 0);
      do_write(32'h10, 32'h0, 4'hF, 0, 0);
      do_read(32'h10, 0);
      do_read(32'h10, 3);

      // randomized concurrent traffic
      bready_mode = 0; rready_mode = 0;
      fork
         repeat (150) begin
            logic [31:0] a, d;
            a = rand_addr();
            d = (a[11:2] == 10'd3) ? 32'($urandom_range(0, 6)) : $urandom();
            do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
         end
         repeat (150) do_read(rand_addr(), $urandom_range(0, 3));
      join
      bready_mode = 1; rready_mode = 1;
      for (int i = 0; i < 50 && (exp_b.size() != 0 || exp_r.size() != 0); i++) @(negedge aclk);
      check("drain_b", 32'(exp_b.size()), 0);
      check("drain_r", 32'(exp_r.size()), 0);

      // stalled response, then reset abort
      bready_mode = 2;
      do_write(32'h4, 32'hCAFE_F00D, 4'hF, 0, 0);
      check("t6_bvalid_up", 32'(s_bvalid), 1);
      held_bresp = s_bresp;
      check("t6_bresp_okay", 32'(held_bresp), 0);
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 32'h8; s_wdata = 32'hF;
      ok = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge aclk);
         if (!s_bvalid || s_bresp !== held_bresp || s_awready || s_wready) ok = 0;
      end
      check("t6_stall_stable", 32'(ok), 1);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      #1 areset = 1'b1;
      #1 check("t6_bvalid_async_clear", 32'(s_bvalid), 0);
      bready_mode = 1;
      repeat (3) @(negedge aclk);
      #1 areset = 1'b0;
      ok = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge aclk);
         if (s_bvalid) ok = 0;
      end
      check("t6_no_resp_after_reset", 32'(ok), 1);
      do_read(32'h4, 0);
      do_read(32'h8, 0);
      for (int i = 0; i < 20 && exp_r.size() != 0; i++) @(negedge aclk);
      check("final_drain_r", 32'(exp_r.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
